tty_transmitter: RTL
====================

Name: tty_transmitter

Overview:
- Teletype/console printer transmitter for the PDP-8/I I/O bus; the send-side counterpart of the keyboard/reader receiver.
- Accepts a character from AC4-11 via IOT, serializes it as an asynchronous start/data/stop frame at the 8x-baud tick rate, and raises the printer flag when the frame completes.
- Decodes its own device code, drives I/O SKIP and the interrupt request, and honours IO CLEAR (initialize).

Parameters:
DEVICE, 6'o04, device code matched against dev_sel
BIT_TICKS, 8, baud_tick pulses per serial bit (8x oversampled clock)
STOP_BITS, 2, stop bits per frame (1 or 2; 2 for 110 baud)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
baud_tick  input  1  one-clk-wide pulse at 8x baud rate
iot  input  1  IOT instruction in progress (device select enable)
dev_sel  input  6  MB3-8 device code
iop1  input  1  IOP1 level strobe (skip on flag)
iop2  input  1  IOP2 level strobe (clear flag)
iop4  input  1  IOP4 level strobe (load and print)
ac  input  8  AC4-11 data; ac[0] = AC11
io_clr  input  1  initialize (CAF / power clear), synchronous, level
ser_out  output  1  serial line, 1 = mark/idle, 0 = space
active  output  1  frame in progress (pending start or shifting)
flag  output  1  printer flag
io_skip  output  1  skip request to processor, active high
int_req  output  1  interrupt request, active high

Behaviour:
- sel = iot & (dev_sel == DEVICE). iopN edge = iopN high this cycle, low the previous cycle (registered history, reset to 0). All actions occur on the rising-edge cycle only; multi-cycle strobes act once.
- io_skip combinational: sel & iop1 & flag. No registered delay.
- iop2 edge with sel: flag <= 0.
- iop4 edge with sel, active = 0: shift register <= ac, active <= 1, state PENDING. Same-cycle iop2 edge (TLS, 6046) clears flag and loads.
- iop4 edge with sel, active = 1: character dropped, frame in progress unaffected; any iop2 clear in that cycle still applies.
- States: IDLE, PENDING, START, DATA, STOP.
  - IDLE: ser_out = 1, active = 0.
  - PENDING -> START on the next baud_tick; ser_out = 0 registered in that cycle. A load coinciding with a tick waits for the following tick.
  - Each bit is held exactly BIT_TICKS baud_ticks. A tick counter (0..BIT_TICKS-1) wraps and advances the bit.
  - START -> DATA. DATA sends 8 bits LSB (ac[0]) first; bit counter 0..7. DATA -> STOP after bit 7's last tick.
  - STOP holds ser_out = 1 for STOP_BITS bits. On the final tick of the last stop bit: state IDLE, active <= 0, flag <= 1, all in the same cycle.
  - Frame length = (9 + STOP_BITS) x BIT_TICKS ticks: default 88 ticks from the first ser_out = 0 to flag set.
- Flag set and iop2 clear edge in the same cycle: set wins (flag = 1).
- io_clr high (any state): next cycle flag = 0, active = 0, state IDLE, ser_out = 1, counters 0. Overrides a simultaneous load and flag set.
- int_req = flag (registered flag, no extra delay) unless the optional feature is compiled in.
- rst_n low: identical to io_clr, plus shift register = 0 and strobe history = 0. Outputs after reset: ser_out = 1, active = 0, flag = 0, io_skip = 0, int_req = 0.
- Reset or io_clr mid-frame truncates the frame immediately (line returns to mark). No flag is set for the aborted character.

Optional Feature:
- Macro TTY_TX_INTCTL_EN.
- Defined: adds int_en register, reset/io_clr value 1. iop1 and iop4 rising edges together with sel (code 5, SPI) set int_en <= ac[0]; this does not load, skip, or clear. int_req = flag & int_en.
- Undefined: no int_en, int_req = flag. Code 5 behaves as separate iop1 (skip) and iop4 (load) actions.

Test Plan:
- Reset then idle 200 ticks -> ser_out = 1, active = 0, flag = 0, io_skip = 0, int_req = 0 throughout.
- TLS (iop2+iop4, dev 04) with ac = 8'h55 -> active = 1; next tick ser_out = 0 for 8 ticks; then bits 1,0,1,0,1,0,1,0 at 8 ticks each; 16 ticks mark; flag = 1 exactly 88 ticks after the start edge.
- Flag set, TSF (iop1, dev 04) -> io_skip = 1 while iop1 high. Same with dev_sel = 03 -> io_skip = 0.
- Second TPC with ac = 8'hFF at tick 40 of a frame carrying 8'h00 -> frame still sends 00; flag sets once, at tick 88.
- io_clr asserted at tick 30 of a frame -> next cycle ser_out = 1, active = 0, flag = 0. A new TPC with 8'h41 then produces a complete frame.
- TTY_TX_INTCTL_EN: SPI with ac[0] = 0, then complete a frame -> flag = 1, int_req = 0. SPI with ac[0] = 1 -> int_req = 1.

Source files
------------

// File: rtl/tty_transmitter.sv
// tty_transmitter: PDP-8/I teletype printer transmitter (IOT decode, start/8 data/stop framing, flag/skip/interrupt).
// Define TTY_TX_INTCTL_EN to add the SPI-controlled interrupt enable.
module tty_transmitter #(
    parameter logic [5:0] DEVICE    = 6'o04,
    parameter int         BIT_TICKS = 8,
    parameter int         STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       iot,
    input  logic [5:0] dev_sel,
    input  logic       iop1,
    input  logic       iop2,
    input  logic       iop4,
    input  logic [7:0] ac,
    input  logic       io_clr,
    output logic       ser_out,
    output logic       active,
    output logic       flag,
    output logic       io_skip,
    output logic       int_req
);
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_TICKS - 1);
    localparam logic [2:0] S_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, PENDING, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [2:0]    bcnt, bcnt_nx;
    logic          ser_nx, flag_nx;
    logic          p2_q, p4_q;
    logic          sel, p2_e, p4_e, load;

    assign sel    = iot && (dev_sel == DEVICE);
    assign p2_e   = sel & iop2 & ~p2_q;
    assign p4_e   = sel & iop4 & ~p4_q;
    assign active = state != IDLE;

`ifdef TTY_TX_INTCTL_EN
    logic p1_q, p1_e, spi, int_en;
    assign p1_e    = sel & iop1 & ~p1_q;
    assign spi     = p1_e & p4_e;
    assign load    = p4_e & ~spi & ~active;
    assign io_skip = sel & iop1 & ~iop4 & flag;
    assign int_req = flag & int_en;
    always_ff @(posedge clk) begin
        p1_q   <= rst_n ? iop1 : 1'b0;
        int_en <= (!rst_n || io_clr) ? 1'b1 : spi ? ac[0] : int_en;
    end
`else
    assign load    = p4_e & ~active;
    assign io_skip = sel & iop1 & flag;
    assign int_req = flag;
`endif

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        tcnt_nx  = tcnt;
        bcnt_nx  = bcnt;
        ser_nx   = ser_out;
        flag_nx  = flag;
        if (p2_e) flag_nx = 1'b0;
        if (load) begin
            state_nx = PENDING;
            shreg_nx = ac;
            tcnt_nx  = '0;
            bcnt_nx  = '0;
        end else if (baud_tick && state != IDLE) begin
            if (state == PENDING) begin
                state_nx = START;
                ser_nx   = 1'b0;
            end else if (tcnt != T_LAST) begin
                tcnt_nx = tcnt + 1'b1;
            end else begin
                // bit boundary: the completion set below must override a same-cycle clear
                tcnt_nx = '0;
                case (state)
                    START: begin
                        state_nx = DATA;
                        ser_nx   = shreg[0];
                        shreg_nx = shreg >> 1;
                    end
                    DATA: begin
                        if (bcnt == 3'd7) begin
                            state_nx = STOP;
                            ser_nx   = 1'b1;
                            bcnt_nx  = '0;
                        end else begin
                            bcnt_nx  = bcnt + 1'b1;
                            ser_nx   = shreg[0];
                            shreg_nx = shreg >> 1;
                        end
                    end
                    STOP: begin
                        if (bcnt == S_LAST) begin
                            state_nx = IDLE;
                            bcnt_nx  = '0;
                            flag_nx  = 1'b1;
                        end else begin
                            bcnt_nx = bcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || io_clr) begin
            state   <= IDLE;
            tcnt    <= '0;
            bcnt    <= '0;
            ser_out <= 1'b1;
            flag    <= 1'b0;
        end else begin
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            bcnt    <= bcnt_nx;
            ser_out <= ser_nx;
            flag    <= flag_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            p2_q  <= 1'b0;
            p4_q  <= 1'b0;
        end else begin
            shreg <= shreg_nx;
            p2_q  <= iop2;
            p4_q  <= iop4;
        end
    end
endmodule
